// File: rtl/sum_tx_sequencer.sv
// sum_tx_sequencer: sequences operand A/B latching, sum computation and a
// 4-byte frame (HEADER, A, B, sum) into a UART transmitter via start/busy.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   save_a_n     async active-low request to latch operand A
//   save_b_n     async active-low request to latch operand B and launch a frame
//   data_input   operand value (synchronized before use)
//   tx_en        transmit enable; low stalls the frame before its next byte
//   tx_busy      UART busy flag
//   tx_start     one-cycle transmit request for tx_data
//   tx_data      byte to transmit, held from tx_start until tx_busy falls
//   op_a, op_b   latched operands
//   sum          registered op_a + op_b, full width
//   frame_active high from frame launch until the last byte completes
//   overrun      sticky flag for a B press during a frame
module sum_tx_sequencer #(
  parameter int unsigned BITS        = 3,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            save_a_n,
  input  logic            save_b_n,
  input  logic [BITS-1:0] data_input,
  input  logic            tx_en,
  input  logic            tx_busy,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  output logic [BITS-1:0] op_a,
  output logic [BITS-1:0] op_b,
  output logic [BITS:0]   sum,
  output logic            frame_active,
  output logic            overrun
);

  localparam int unsigned SW = BITS + 1;
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HAVE_A  = 3'd1;
  localparam logic [2:0] CALC    = 3'd2;
  localparam logic [2:0] LOAD    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_HI = 3'd5;
  localparam logic [2:0] WAIT_LO = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [1:0]      idx_q;
  logic [CW-1:0]   cnt_q;
  // [0],[1] synchronizer stages, [2] previous synchronized level for edge detect
  logic [2:0]      a_sync_q, b_sync_q;
  logic [BITS-1:0] d_meta_q, d_sync_q;
  logic            a_press, b_press, a_take, b_take, in_tx;
  logic [7:0]      byte_sel;

  assign a_press = a_sync_q[2] & ~a_sync_q[1];
  assign b_press = b_sync_q[2] & ~b_sync_q[1];
  assign in_tx   = (state_q == SEND) || (state_q == WAIT_HI) || (state_q == WAIT_LO);
  assign a_take  = a_press && !in_tx;
  assign b_take  = b_press && ((state_q == IDLE) || (state_q == HAVE_A));
  assign tx_start = (state_q == SEND);

  always_comb begin
    byte_sel = HEADER;
    case (idx_q)
      2'd0:    byte_sel = HEADER;
      2'd1:    byte_sel = 8'(op_a);
      2'd2:    byte_sel = 8'(op_b);
      default: byte_sel = 8'(sum);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (b_take)       state_d = CALC;
        else if (a_press) state_d = HAVE_A;
      end
      HAVE_A:  if (b_take) state_d = CALC;
      CALC:    state_d = LOAD;
      LOAD:    if (tx_en && !tx_busy) state_d = SEND;
      SEND:    state_d = WAIT_HI;
      WAIT_HI: begin
        // SEND counts as the first wait cycle, so a retry pulse lands
        // exactly ACK_TIMEOUT+1 cycles after the previous one.
        if (tx_busy)                               state_d = WAIT_LO;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1))    state_d = LOAD;
      end
      WAIT_LO: if (!tx_busy) state_d = (idx_q == 2'd3) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      a_sync_q     <= '1;
      b_sync_q     <= '1;
      d_meta_q     <= '0;
      d_sync_q     <= '0;
      tx_data      <= '0;
      op_a         <= '0;
      op_b         <= '0;
      sum          <= '0;
      frame_active <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sync_q <= {a_sync_q[1:0], save_a_n};
      b_sync_q <= {b_sync_q[1:0], save_b_n};
      d_meta_q <= data_input;
      d_sync_q <= d_meta_q;

      if (a_take) op_a <= d_sync_q;
      if (b_take) op_b <= d_sync_q;
      if (b_press && frame_active) overrun <= 1'b1;

      case (state_q)
        CALC: begin
          sum          <= SW'(op_a) + SW'(op_b);
          overrun      <= 1'b0;
          frame_active <= 1'b1;
          idx_q        <= '0;
        end
        LOAD: begin
          tx_data <= byte_sel;
          cnt_q   <= '0;
        end
        SEND:    cnt_q <= cnt_q + CW'(1);
        WAIT_HI: if (!tx_busy) cnt_q <= cnt_q + CW'(1);
        WAIT_LO: begin
          if (!tx_busy) begin
            if (idx_q == 2'd3) frame_active <= 1'b0;
            else               idx_q        <= idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
